// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the IF->ID pipeline register.
//   - Default field widths and the default NOP instruction (sll $0,$0,0).
//   - Control FSM state encoding (EMPTY / ONE / FULL).
//   - Source select for the main (M) register.
// -----------------------------------------------------------------------------
package pipe_pkg;

    localparam int          PIPE_ADDR_W    = 32;
    localparam int          PIPE_INSTR_W   = 32;
    localparam logic [31:0] PIPE_NOP_INSTR = 32'h0000_0000;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    typedef enum logic [1:0] {
        STATE_EMPTY = ST_EMPTY,
        STATE_ONE   = ST_ONE,
        STATE_FULL  = ST_FULL
    } state_e;

    // What the main register loads on the coming edge.
    typedef enum logic [1:0] {
        M_HOLD    = 2'd0,
        M_FROM_IN = 2'd1,
        M_FROM_S  = 2'd2,
        M_CLEAR   = 2'd3
    } m_src_e;

endpackage

// File: rtl/pipe_field_reg.sv
// -----------------------------------------------------------------------------
// pipe_field_reg
// Parametrised-width register with asynchronous active-high reset to RST_VAL
// and a synchronous load enable. Used for both the main and the skid entry.
// Ports:
//   clk    - clock, rising edge
//   rst    - asynchronous active-high reset
//   i_load - load i_d on the next rising edge
//   i_d    - data to load
//   o_q    - registered value
// -----------------------------------------------------------------------------
module pipe_field_reg #(
    parameter int           W       = 32,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= RST_VAL;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/if_id_pipe.sv
// -----------------------------------------------------------------------------
// if_id_pipe
// IF->ID pipeline register with valid/ready handshake, a 2-entry skid buffer
// (main register M drives the outputs, skid register S holds the overflow) and
// a flush that kills held and incoming instructions, presenting NOP_INSTR.
//
// Optional feature, macro IF_ID_STALL_CNT_EN: adds output stall_cnt[31:0],
// a saturating count of cycles with out_valid && !out_ready (reset-only clear).
//
// Ports:
//   clk, rst                    - clock; asynchronous active-high reset
//   in_valid/in_ready           - IF side handshake (in_ready registered)
//   in_pc/in_instr/in_pc_plus4  - fetched entry
//   flush                       - discard everything, highest priority
//   out_valid/out_ready         - ID side handshake
//   out_pc/out_instr/out_pc_plus4 - entry to ID (out_instr=NOP_INSTR if invalid)
// -----------------------------------------------------------------------------
module if_id_pipe
    import pipe_pkg::*;
#(
    parameter int                 ADDR_W    = PIPE_ADDR_W,
    parameter int                 INSTR_W   = PIPE_INSTR_W,
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(PIPE_NOP_INSTR)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [ADDR_W-1:0]  in_pc,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [ADDR_W-1:0]  in_pc_plus4,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ADDR_W-1:0]  out_pc,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc_plus4
`ifdef IF_ID_STALL_CNT_EN
    ,
    output logic [31:0]        stall_cnt
`endif
);

    // Entry layout: {pc, instr, pc_plus4}
    localparam int ENTRY_W = 2 * ADDR_W + INSTR_W;
    localparam logic [ENTRY_W-1:0] CLEAR_ENTRY = {{ADDR_W{1'b0}}, NOP_INSTR, {ADDR_W{1'b0}}};

    state_e             r_state;
    state_e             w_state_next;
    logic               r_in_ready;
    logic               r_out_valid;
    m_src_e             w_m_src;
    logic               w_m_load;
    logic               w_s_load;
    logic [ENTRY_W-1:0] w_in_entry;
    logic [ENTRY_W-1:0] w_m_d;
    logic [ENTRY_W-1:0] w_s_d;
    logic [ENTRY_W-1:0] w_m_q;
    logic [ENTRY_W-1:0] w_s_q;
    logic               w_accept;
    logic               w_drain;

    assign w_in_entry = {in_pc, in_instr, in_pc_plus4};
    assign w_accept   = in_valid && r_in_ready;
    assign w_drain    = r_out_valid && out_ready;

    // Next-state and datapath control. Flush overrides everything; a drain in
    // the flush cycle is simply not replayed because M is cleared.
    always_comb begin
        w_state_next = r_state;
        w_m_src      = M_HOLD;
        w_s_load     = 1'b0;
        w_s_d        = w_in_entry;
        if (flush) begin
            w_state_next = STATE_EMPTY;
            w_m_src      = M_CLEAR;
            w_s_load     = 1'b1;
            w_s_d        = CLEAR_ENTRY;
        end else begin
            case (r_state)
                STATE_EMPTY: begin
                    if (w_accept) begin
                        w_state_next = STATE_ONE;
                        w_m_src      = M_FROM_IN;
                    end
                end
                STATE_ONE: begin
                    if (w_accept && w_drain) begin
                        w_m_src = M_FROM_IN;
                    end else if (w_accept) begin
                        w_state_next = STATE_FULL;
                        w_s_load     = 1'b1;
                    end else if (w_drain) begin
                        // Clearing M is what makes out_instr read NOP when empty.
                        w_state_next = STATE_EMPTY;
                        w_m_src      = M_CLEAR;
                    end
                end
                STATE_FULL: begin
                    if (w_drain) begin
                        w_state_next = STATE_ONE;
                        w_m_src      = M_FROM_S;
                        w_s_load     = 1'b1;
                        w_s_d        = CLEAR_ENTRY;
                    end
                end
                default: begin
                    w_state_next = STATE_EMPTY;
                    w_m_src      = M_CLEAR;
                    w_s_load     = 1'b1;
                    w_s_d        = CLEAR_ENTRY;
                end
            endcase
        end
    end

    always_comb begin
        w_m_d = w_m_q;
        case (w_m_src)
            M_FROM_IN: w_m_d = w_in_entry;
            M_FROM_S:  w_m_d = w_s_q;
            M_CLEAR:   w_m_d = CLEAR_ENTRY;
            default:   w_m_d = w_m_q;
        endcase
    end

    assign w_m_load = (w_m_src != M_HOLD);

    // Handshake flags are registered copies decoded from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= STATE_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_in_ready  <= (w_state_next != STATE_FULL);
            r_out_valid <= (w_state_next != STATE_EMPTY);
        end
    end

    pipe_field_reg #(.W(ENTRY_W), .RST_VAL(CLEAR_ENTRY)) u_m_reg (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_m_load),
        .i_d    (w_m_d),
        .o_q    (w_m_q)
    );

    pipe_field_reg #(.W(ENTRY_W), .RST_VAL(CLEAR_ENTRY)) u_s_reg (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_s_load),
        .i_d    (w_s_d),
        .o_q    (w_s_q)
    );

    assign in_ready     = r_in_ready;
    assign out_valid    = r_out_valid;
    assign out_pc       = w_m_q[ENTRY_W-1 -: ADDR_W];
    assign out_instr    = w_m_q[ADDR_W +: INSTR_W];
    assign out_pc_plus4 = w_m_q[ADDR_W-1:0];

`ifdef IF_ID_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= 32'd0;
        end else if (r_out_valid && !out_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    // Stall counter not built.
`endif

endmodule
